// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the unified memory port arbiter: the access-size
// encodings, the arbiter FSM states, the owner tag and the alignment rule
// applied to data-stage requests.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  // Byte accesses are always aligned; unknown size codes are let through.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    return ((size == SZ_WORD) && (addr_lo != 2'b00)) ||
           ((size == SZ_HALF) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/arb_priority.sv
// arb_priority
// Winner select between instruction fetch and data requests, plus the
// starvation counter that bounds how many data grants in a row can pass a
// waiting fetch.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   arb_en            arbiter is idle and may grant this cycle
//   if_req, dm_req    pending requests
//   grant_if/grant_dm one-hot grant (both 0 when idle or nothing pending)
module arb_priority #(
  parameter int MAX_DM_CONSEC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic if_req,
  input  logic dm_req,
  output logic grant_if,
  output logic grant_dm
);

  localparam int SW = $clog2(MAX_DM_CONSEC + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_DM_CONSEC);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          if_forced;

  always_comb begin
    // Once fetch has watched MAX_DM_CONSEC data grants go by it takes the port.
    if_forced    = if_req && (starve_cnt_q == STARVE_MAX);
    grant_dm     = arb_en && dm_req && !if_forced;
    grant_if     = arb_en && if_req && !grant_dm;

    starve_cnt_d = starve_cnt_q;
    if (grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_dm) begin
      if (!if_req) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_MAX) begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares a single memory port between instruction fetch (read-only, word)
// and the data memory stage (read/write, byte/half/word). Each access runs
// IDLE -> ISSUE -> WAIT -> RESP; data has priority, fetch is protected from
// starvation by arb_priority.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   if_req/if_addr                  fetch request, held until if_done
//   if_rdata/if_done                fetched word and its completion pulse
//   dm_req/dm_addr/dm_wdata/
//   dm_size/dm_rw                   data request, held until dm_done
//   dm_rdata/dm_done/dm_err         load data, completion, misalignment error
//   stall_if/stall_mm               pipeline stalls (req & ~done)
//   mem_addr/mem_data_in/
//   mem_access_size/mem_rd_wr/
//   mem_enable                      memory command, held while mem_busy
//   mem_data_out/mem_busy           memory response / back-pressure
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LAT       = 1,
  parameter int MAX_DM_CONSEC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [1:0]  dm_size,
  input  logic        dm_rw,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_err,
  output logic        stall_if,
  output logic        stall_mm,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_access_size,
  output logic        mem_rd_wr,
  output logic        mem_enable,
  input  logic [31:0] mem_data_out,
  input  logic        mem_busy
);

  localparam int WW = $clog2(MEM_LAT + 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(MEM_LAT - 1);

  arb_state_t    state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   req_wdata_q, req_wdata_d;
  logic [1:0]    req_size_q, req_size_d;
  logic          req_rw_q, req_rw_d;
  logic          req_err_q, req_err_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;
  logic          dm_err_q, dm_err_d;
  logic          mem_enable_q, mem_enable_d;
  logic          grant_if, grant_dm;

  arb_priority #(
    .MAX_DM_CONSEC(MAX_DM_CONSEC)
  ) u_arb_priority (
    .clk     (clk),
    .reset   (reset),
    .arb_en  (state_q == IDLE),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .grant_if(grant_if),
    .grant_dm(grant_dm)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_size_d   = req_size_q;
    req_rw_d     = req_rw_q;
    req_err_d    = req_err_q;
    wait_cnt_d   = wait_cnt_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    dm_err_d     = 1'b0;
    mem_enable_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_dm) begin
          owner_d      = OWN_DM;
          req_addr_d   = dm_addr;
          req_wdata_d  = dm_wdata;
          req_size_d   = dm_size;
          req_rw_d     = dm_rw;
          req_err_d    = is_misaligned(dm_size, dm_addr[1:0]);
          mem_enable_d = !req_err_d;
          state_d      = ISSUE;
        end else if (grant_if) begin
          owner_d      = OWN_IF;
          req_addr_d   = if_addr;
          req_wdata_d  = '0;
          req_size_d   = SZ_WORD;
          req_rw_d     = 1'b1;
          req_err_d    = 1'b0;
          mem_enable_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // A misaligned request spends its ISSUE slot with the strobe low and
        // reports the error without ever touching memory.
        if (req_err_q) begin
          dm_done_d = 1'b1;
          dm_err_d  = 1'b1;
          state_d   = RESP;
        end else if (mem_busy) begin
          mem_enable_d = 1'b1;
        end else begin
          wait_cnt_d = WAIT_LOAD;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          if (owner_q == OWN_IF) begin
            if_done_d = 1'b1;
            if (req_rw_q) if_rdata_d = mem_data_out;
          end else begin
            dm_done_d = 1'b1;
            if (req_rw_q) dm_rdata_d = mem_data_out;
          end
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - WW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_size_q   <= SZ_BYTE;
      req_rw_q     <= 1'b1;
      req_err_q    <= 1'b0;
      wait_cnt_q   <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
      dm_err_q     <= 1'b0;
      mem_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_size_q   <= req_size_d;
      req_rw_q     <= req_rw_d;
      req_err_q    <= req_err_d;
      wait_cnt_q   <= wait_cnt_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
      dm_err_q     <= dm_err_d;
      mem_enable_q <= mem_enable_d;
    end
  end

  assign if_rdata        = if_rdata_q;
  assign if_done         = if_done_q;
  assign dm_rdata        = dm_rdata_q;
  assign dm_done         = dm_done_q;
  assign dm_err          = dm_err_q;
  assign stall_if        = if_req & ~if_done_q;
  assign stall_mm        = dm_req & ~dm_done_q;
  assign mem_addr        = req_addr_q;
  assign mem_data_in     = req_wdata_q;
  assign mem_access_size = req_size_q;
  assign mem_rd_wr       = req_rw_q;
  assign mem_enable      = mem_enable_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios followed by a randomized run, all checked every cycle
// against a transaction-level model of the arbiter and a simple memory.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int MEM_LAT       = 1;
  localparam int MAX_DM_CONSEC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [1:0]  dm_size;
  logic        dm_rw;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        dm_err;
  logic        stall_if;
  logic        stall_mm;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rd_wr;
  logic        mem_enable;
  logic [31:0] mem_data_out;
  logic        mem_busy;

  mem_port_arbiter #(
    .MEM_LAT      (MEM_LAT),
    .MAX_DM_CONSEC(MAX_DM_CONSEC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_rdata       (if_rdata),
    .if_done        (if_done),
    .dm_req         (dm_req),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_size        (dm_size),
    .dm_rw          (dm_rw),
    .dm_rdata       (dm_rdata),
    .dm_done        (dm_done),
    .dm_err         (dm_err),
    .stall_if       (stall_if),
    .stall_mm       (stall_mm),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_access_size(mem_access_size),
    .mem_rd_wr      (mem_rd_wr),
    .mem_enable     (mem_enable),
    .mem_data_out   (mem_data_out),
    .mem_busy       (mem_busy)
  );

  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int cyc;

  // Reference model: one in-flight transaction plus the starvation count.
  bit          act;
  bit          t_dm;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [1:0]  t_size;
  bit          t_rw;
  bit          t_err;
  int          t_grant;
  int          t_accept;
  int          t_done;
  int          starve;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_dm_rdata;
  bit          prev_if_done;
  bit          prev_dm_done;

  // Memory: data valid exactly MEM_LAT cycles after an accepted issue.
  int          due_cyc;
  logic [31:0] due_data;
  logic [31:0] mem_table [logic [31:0]];

  // Observations of the DUT used by the directed checks.
  int          last_if_done_cyc;
  int          last_dm_done_cyc;
  int          last_err_cyc;
  int          en_count;
  int          dm_done_count;
  int          if_done_cycs [$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (mem_table.exists(a)) return mem_table[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic apply_reset();
    reset        = 1'b0;
    act          = 1'b0;
    starve       = 0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    due_cyc      = -1;
    prev_if_done = 1'b0;
    prev_dm_done = 1'b0;
  endtask

  // Called at the falling edge once this cycle's inputs are set.
  task automatic run_cycle();
    bit e_en, e_if_done, e_dm_done, e_err, g_dm;
    #1;
    e_en      = act && !t_err && (cyc > t_grant) && (t_accept < 0);
    e_if_done = act && !t_dm && (t_done == cyc);
    e_dm_done = act && t_dm && (t_done == cyc);
    e_err     = e_dm_done && t_err;
    if ((e_if_done || e_dm_done) && t_rw && !t_err) begin
      if (t_dm) exp_dm_rdata = mem_fn(t_addr);
      else      exp_if_rdata = mem_fn(t_addr);
    end

    check("if_done", 32'(if_done), 32'(e_if_done));
    check("dm_done", 32'(dm_done), 32'(e_dm_done));
    check("dm_err", 32'(dm_err), 32'(e_err));
    check("mem_enable", 32'(mem_enable), 32'(e_en));
    check("if_rdata", if_rdata, exp_if_rdata);
    check("dm_rdata", dm_rdata, exp_dm_rdata);
    check("stall_if", 32'(stall_if), 32'(if_req && !e_if_done));
    check("stall_mm", 32'(stall_mm), 32'(dm_req && !e_dm_done));
    if (e_en) begin
      check("mem_addr", mem_addr, t_addr);
      check("mem_size", 32'(mem_access_size), 32'(t_size));
      check("mem_rd_wr", 32'(mem_rd_wr), 32'(t_rw));
      if (!t_rw) check("mem_data_in", mem_data_in, t_wdata);
    end

    if (if_done) begin
      last_if_done_cyc = cyc;
      if_done_cycs.push_back(cyc);
    end
    if (dm_done) begin
      last_dm_done_cyc = cyc;
      dm_done_count++;
    end
    if (dm_err) last_err_cyc = cyc;
    if (mem_enable) en_count++;

    mem_data_out = (due_cyc == cyc) ? due_data : 32'($urandom);
    if (mem_enable && !mem_busy) begin
      due_cyc  = cyc + MEM_LAT;
      due_data = mem_fn(mem_addr);
    end

    prev_if_done = e_if_done;
    prev_dm_done = e_dm_done;
    if (reset === 1'b1) begin
      if (act) begin
        if (!t_err && (t_accept < 0) && (cyc > t_grant) && !mem_busy) begin
          t_accept = cyc;
          t_done   = cyc + 1 + MEM_LAT;
        end
        if (cyc == t_done) act = 1'b0;
      end else if (if_req || dm_req) begin
        g_dm     = dm_req && !(if_req && (starve == MAX_DM_CONSEC));
        act      = 1'b1;
        t_dm     = g_dm;
        t_grant  = cyc;
        t_accept = -1;
        if (g_dm) begin
          starve  = if_req ? ((starve < MAX_DM_CONSEC) ? starve + 1 : MAX_DM_CONSEC) : 0;
          t_addr  = dm_addr;
          t_wdata = dm_wdata;
          t_size  = dm_size;
          t_rw    = dm_rw;
          t_err   = ((dm_size == SZ_WORD) && (dm_addr % 4 != 0)) ||
                    ((dm_size == SZ_HALF) && (dm_addr % 2 != 0));
        end else begin
          starve  = 0;
          t_addr  = if_addr;
          t_wdata = '0;
          t_size  = SZ_WORD;
          t_rw    = 1'b1;
          t_err   = 1'b0;
        end
        t_done = t_err ? cyc + 2 : -1;
      end
    end

    @(negedge clk);
    cyc++;
  endtask

  // Runs n cycles; a requester drops its request the cycle after its done
  // unless it is asked to keep requesting.
  task automatic run_hold(input int n, input bit keep_if, input bit keep_dm);
    for (int i = 0; i < n; i++) begin
      if (prev_if_done && !keep_if) if_req = 1'b0;
      if (prev_dm_done && !keep_dm) dm_req = 1'b0;
      run_cycle();
    end
  endtask

  int t;
  int c0;

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_size  = SZ_WORD;
    dm_rw    = 1'b1;
    mem_busy = 1'b0;
    mem_data_out = '0;
    t_grant  = 0;
    t_accept = -1;
    t_done   = -1;
    t_err    = 1'b0;
    last_if_done_cyc = -1;
    last_dm_done_cyc = -1;
    last_err_cyc     = -1;
    en_count      = 0;
    dm_done_count = 0;
    mem_table[32'h0040_0000] = 32'h2402_0005;
    mem_table[32'h0000_1000] = 32'hDEAD_BEEF;
    reset = 1'b1;
    #2;
    apply_reset();
    @(negedge clk);
    run_cycle();
    run_cycle();
    reset = 1'b1;

    // Fetch only.
    t = cyc; en_count = 0;
    if_req = 1'b1; if_addr = 32'h0040_0000;
    run_hold(5, 1'b0, 1'b0);
    check("t1_if_done_at", 32'(last_if_done_cyc - t), 32'd3);
    check("t1_enable_cycles", 32'(en_count), 32'd1);
    check("t1_if_rdata", if_rdata, 32'h2402_0005);

    // Simultaneous requests: data first, fetch after the bubble.
    t = cyc;
    if_req = 1'b1; if_addr = 32'h0040_0010;
    dm_req = 1'b1; dm_addr = 32'h0000_1000; dm_rw = 1'b1; dm_size = SZ_WORD;
    run_hold(9, 1'b0, 1'b0);
    check("t2_dm_done_at", 32'(last_dm_done_cyc - t), 32'd3);
    check("t2_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    check("t2_if_done_at", 32'(last_if_done_cyc - t), 32'd7);

    // Data held continuously while fetch waits: four data grants, then fetch.
    t = cyc; if_done_cycs.delete(); dm_done_count = 0;
    if_req = 1'b1; if_addr = 32'h0040_0020;
    dm_req = 1'b1; dm_addr = 32'h0000_3000; dm_rw = 1'b1; dm_size = SZ_WORD;
    run_hold(40, 1'b1, 1'b1);
    check("t3_if_done_count", 32'(if_done_cycs.size()), 32'd2);
    check("t3_dm_done_count", 32'(dm_done_count), 32'd8);
    if (if_done_cycs.size() >= 2) begin
      check("t3_first_if_at", 32'(if_done_cycs[0] - t), 32'd19);
      check("t3_second_if_at", 32'(if_done_cycs[1] - t), 32'd39);
    end
    if_req = 1'b0; dm_req = 1'b0;
    run_cycle();

    // Half-word store with two busy cycles.
    t = cyc; en_count = 0;
    dm_req = 1'b1; dm_rw = 1'b0; dm_addr = 32'h0000_2002; dm_size = SZ_HALF;
    dm_wdata = 32'h0000_ABCD;
    run_cycle();
    mem_busy = 1'b1;
    run_cycle();
    run_cycle();
    mem_busy = 1'b0;
    run_hold(4, 1'b0, 1'b0);
    check("t4_dm_done_at", 32'(last_dm_done_cyc - t), 32'd5);
    check("t4_enable_cycles", 32'(en_count), 32'd3);
    check("t4_dm_rdata_kept", dm_rdata, mem_fn(32'h0000_3000));

    // Misaligned word read.
    t = cyc; en_count = 0;
    dm_req = 1'b1; dm_rw = 1'b1; dm_addr = 32'h0000_1001; dm_size = SZ_WORD;
    run_hold(4, 1'b0, 1'b0);
    check("t5_dm_done_at", 32'(last_dm_done_cyc - t), 32'd2);
    check("t5_err_with_done", 32'(last_err_cyc), 32'(last_dm_done_cyc));
    check("t5_enable_cycles", 32'(en_count), 32'd0);
    check("t5_dm_rdata_kept", dm_rdata, mem_fn(32'h0000_3000));

    // Reset during WAIT abandons the fetch; it is re-granted afterwards.
    t = cyc; c0 = if_done_cycs.size();
    if_req = 1'b1; if_addr = 32'h0040_0000;
    run_cycle();
    run_cycle();
    apply_reset();
    #1;
    check("t6_rst_rd_wr", 32'(mem_rd_wr), 32'd1);
    check("t6_rst_addr", mem_addr, 32'h0);
    check("t6_rst_if_rdata", if_rdata, 32'h0);
    run_cycle();
    run_cycle();
    reset = 1'b1;
    t = cyc;
    run_hold(5, 1'b0, 1'b0);
    check("t6_if_done_count", 32'(if_done_cycs.size() - c0), 32'd1);
    check("t6_if_done_at", 32'(last_if_done_cyc - t), 32'd3);
    check("t6_if_rdata", if_rdata, 32'h2402_0005);

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 800; i++) begin
      if (!if_req || prev_if_done) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = 32'($urandom);
      end
      if (!dm_req || prev_dm_done) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_addr  = 32'($urandom);
        dm_size  = 2'($urandom_range(0, 2));
        dm_rw    = 1'($urandom_range(0, 1));
        dm_wdata = 32'($urandom);
      end
      mem_busy = ($urandom_range(0, 3) == 0);
      run_cycle();
    end
    mem_busy = 1'b0;
    run_hold(12, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port (addr, data_in, access_size, rd_wr, enable, data_out, busy) between two requesters: instruction fetch (IF, read-only) and data memory stage (MM, read/write).
- Sits between the pipeline and the single memory instance. It sequences each access through issue, wait and response.
- Provides per-requester done/rdata and stall outputs to the pipeline control.
- Data has priority over fetch, with a starvation guard for fetch.

Parameters:
- MEM_LAT, 1, cycles from accepted issue until mem_data_out is valid (≥1).
- MAX_DM_CONSEC, 4, maximum consecutive DM grants while IF is pending before IF is forced.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request (held until if_done)
- if_addr  in  32  fetch address (word access)
- if_rdata  out  32  fetched instruction, valid when if_done
- if_done  out  1  one-cycle completion pulse
- dm_req  in  1  data request (held until dm_done)
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_size  in  2  access size (SZ_BYTE/SZ_HALF/SZ_WORD)
- dm_rw  in  1  1=read, 0=write
- dm_rdata  out  32  load data, valid when dm_done
- dm_done  out  1  one-cycle completion pulse
- dm_err  out  1  misalignment error pulse, coincident with dm_done
- stall_if  out  1  if_req & ~if_done
- stall_mm  out  1  dm_req & ~dm_done
- mem_addr  out  32  to memory
- mem_data_in  out  32  to memory
- mem_access_size  out  2  to memory
- mem_rd_wr  out  1  to memory, 1=read
- mem_enable  out  1  issue strobe
- mem_data_out  in  32  from memory
- mem_busy  in  1  memory cannot accept issue

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE; starvation counter=0; all registered outputs 0; mem_rd_wr=1.
  - Any in-flight access is abandoned with no done pulse.
  - Leaving reset resumes at IDLE on the next clk edge.
- FSM states IDLE, ISSUE, WAIT, RESP; the owner register (IF/DM) is latched on grant.
- IDLE, arbitration:
  - Only dm_req: DM wins.
  - Only if_req: IF wins.
  - Both: DM wins, unless starve_cnt == MAX_DM_CONSEC, then IF wins.
  - Grant latches addr/wdata/size/rw (IF forces SZ_WORD, read) into the request register and goes to ISSUE.
  - Neither: stay IDLE.
- Starvation counter:
  - Increments on each DM grant while if_req=1.
  - Clears on any IF grant, or on a DM grant with if_req=0.
  - Saturates at MAX_DM_CONSEC.
- DM alignment check at grant:
  - SZ_WORD with addr[1:0]≠0, or SZ_HALF with addr[0]≠0, is misaligned.
  - Misaligned: skip memory and go directly to RESP with dm_err=1. dm_rdata is unchanged.
- ISSUE:
  - mem_enable=1; mem_* driven from the request register.
  - mem_busy=1: stay in ISSUE, holding all mem_* stable.
  - mem_busy=0: access accepted; load wait counter = MEM_LAT-1 and go to WAIT.
- WAIT:
  - mem_enable=0.
  - Counter decrements each cycle. When it reaches 0, capture mem_data_out into the owner's rdata (reads only) and go to RESP.
  - WAIT lasts exactly MEM_LAT cycles.
- RESP:
  - The owner's done pulses for 1 cycle. Writes pulse done without changing rdata.
  - Next state IDLE; the next grant happens in IDLE, giving a 1-cycle bubble between accesses.
- Latency with mem_busy=0: request seen in IDLE at cycle t gives done at cycle t+2+MEM_LAT. Each cycle of mem_busy adds one cycle.
- Requester rules:
  - Requester signals are sampled only at grant; later changes have no effect on the in-flight access.
  - A req dropped before grant is never serviced.
  - The non-owner's req stays pending, and its stall output stays high.
- if_rdata/dm_rdata hold their last captured value until overwritten.
- stall_if/stall_mm are combinational from req and done.
- Widths: the wait counter is $clog2(MEM_LAT+1) bits; the starvation counter is $clog2(MAX_DM_CONSEC+1) bits.

Decomposition:
- Shared package mem_pkg:
  - access-size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP};
  - owner_t enum {OWN_IF, OWN_DM}.
- One natural sub-module, arb_priority: the combinational winner select plus the starvation counter register.
- FSM, request register and response capture stay in mem_port_arbiter.

Test Plan:
- IF only, MEM_LAT=1, if_addr=0x00400000, memory returns 0x24020005:
  - mem_enable high exactly 1 cycle at t+1;
  - if_done at t+3 with if_rdata=0x24020005;
  - stall_if high for t..t+2.
- Simultaneous if_req and dm_req (read, addr=0x1000, SZ_WORD, returns 0xDEADBEEF):
  - DM served first (dm_done t+3, dm_rdata=0xDEADBEEF);
  - IF granted in the following IDLE, if_done at t+7.
- dm_req held continuously (MAX_DM_CONSEC=4) with if_req pending:
  - four DM completions, then the fifth grant goes to IF;
  - counter cleared afterwards.
- Store dm_rw=0, addr=0x2002, SZ_HALF, wdata=0x0000ABCD, mem_busy high 2 cycles:
  - ISSUE held 3 cycles with stable mem_* (mem_rd_wr=0, size=SZ_HALF);
  - dm_done at t+5;
  - dm_rdata unchanged.
- Misaligned SZ_WORD at 0x1001:
  - no mem_enable;
  - dm_done and dm_err pulse together at t+2.
- reset asserted during WAIT (MEM_LAT=3):
  - all outputs 0 immediately, no done pulse;
  - after release, a pending if_req is granted normally.
